wptr_full_2: RTL and testbench
==============================

Name: wptr_full_2

Overview:
- Write-side pointer and full-flag logic for the dual-clock FIFO; the counterpart of the read-pointer/empty block on the read side.
- Keeps the binary write address and the Gray-coded write pointer (wptr) that crosses into the read domain.
- Compares wptr with the read pointer (wq2_rptr), already synchronized into the write domain, to raise wfull.
- Also provides a pessimistic fill level, a programmable almost-full flag, a sticky overflow flag and a saturating count of dropped writes.

Parameters:
- ADDRSIZE, 7, memory address width; FIFO depth = 2^ADDRSIZE; must be >= 2.
- AFULL_THRESH, 120, fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.
- DROPW, 8, width of the dropped-write counter.

Ports:
- wclk  input  1  write-domain clock
- wrst_n  input  1  asynchronous active-low reset
- winc  input  1  write request for this cycle
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk
- wclr_ovf  input  1  clears woverflow and wdrop_cnt
- wfull  output  1  FIFO full, registered
- waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0]
- wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchronizer
- wlevel  output  ADDRSIZE+1  registered fill level, range 0..2^ADDRSIZE
- walmost_full  output  1  registered, wlevel >= AFULL_THRESH
- woverflow  output  1  sticky; set by a write attempted while full
- wdrop_cnt  output  DROPW  saturating count of writes rejected while full

Behaviour:
- One clock (wclk). Reset is asynchronous, active-low (wrst_n).
- Reset values: wbin=0, wptr=0, wfull=0, wlevel=0, walmost_full=0, woverflow=0, wdrop_cnt=0. Reset asserted mid-operation clears all of these immediately, with no dependence on wclk.
- Write acceptance: wen = winc & ~wfull.
  - wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - wbin and wptr load wbinnext and wgraynext on every wclk edge.
- waddr is combinational from wbin and selects the location written at the current edge when wen=1.
- Full detection: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull rises on the same edge that accepts the 2^ADDRSIZE-th outstanding write. There is no extra cycle of latency.
- Read-pointer conversion: rbin_s is the combinational Gray-to-binary conversion of wq2_rptr (MSB passes through; each lower bit = its Gray bit XOR the next-higher binary bit).
- Level: wlevel <= wbinnext - rbin_s, modulo 2^(ADDRSIZE+1).
  - Because wq2_rptr lags the true read pointer, the level is pessimistic: it never under-reports occupancy.
  - wlevel = 2^ADDRSIZE exactly when wfull is set at the same edge.
- walmost_full <= (wbinnext - rbin_s) >= AFULL_THRESH. It updates on the same edge as wlevel.
- Overflow and drops:
  - When winc & wfull: woverflow <= 1, and wdrop_cnt increments, saturating at all-ones.
  - wclr_ovf clears both on the next edge.
  - If wclr_ovf and a drop occur in the same cycle, the drop wins: woverflow=1 and wdrop_cnt=1.
- Wrap-around: wbin goes from 2^(ADDRSIZE+1)-1 to 0. The extra MSB disambiguates full from empty. wptr changes exactly one bit per accepted write.
- A write and a read-pointer advance in the same cycle are both reflected in wfull and wlevel at that edge.
- A winc held while full leaves wbin and wptr unchanged.
- No combinational path from winc to wfull. wfull is a function of registered state and wq2_rptr only.

Test Plan (defaults: ADDRSIZE=7, depth 128, AFULL_THRESH=120):
1. Reset -> wfull=0, wptr=8'h00, waddr=0, wlevel=0, walmost_full=0, woverflow=0, wdrop_cnt=0.
2. wq2_rptr=0, 128 consecutive winc.
   - walmost_full=1 after the 120th edge.
   - wfull=1, wlevel=128 and wptr=8'hC0 after the 128th edge.
   - waddr=0 after the 128th edge.
3. Full state, 3 more winc, then one cycle of wclr_ovf.
   - During the extra winc: wptr holds 8'hC0, woverflow=1, wdrop_cnt=3.
   - After wclr_ovf: woverflow=0, wdrop_cnt=0.
4. Full state, drive wq2_rptr=8'h07 (Gray of 5), no winc -> after the next edge wfull=0, wlevel=123, walmost_full=1.
5. Wrap: continuous writes with the read pointer trailing by 10 for 600 cycles.
   - wbin wraps from 255 to 0.
   - wptr has Hamming distance 1 per accepted write.
   - wfull never asserts.
   - wlevel stays at 10 or 11.
6. Assert wrst_n=0 mid-burst, between clock edges -> all outputs return to reset values immediately. Writes resume from waddr=0 after release.

Source files
------------

// File: rtl/wptr_full_2.sv
// Write-side pointer, full flag and occupancy bookkeeping for a dual-clock FIFO.
// Keeps binary and Gray write pointers and compares against the synchronized read pointer.
module wptr_full_2 #(
    parameter int ADDRSIZE     = 7,
    parameter int AFULL_THRESH = 120,
    parameter int DROPW        = 8
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wclr_ovf,
    output logic                wfull,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                woverflow,
    output logic [DROPW-1:0]    wdrop_cnt
);

    localparam logic [ADDRSIZE:0] AF_TH = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next;
    logic              wen;
    logic              drop;
    logic              full_next;

    // Handshake: a write is accepted on a wclk edge when winc=1 and wfull=0;
    // winc with wfull=1 is rejected, counted as a drop, and leaves the pointers untouched.
    assign wen       = winc & ~wfull;
    assign drop      = winc & wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_gray2bin
        assign rbin_s[i] = ^(wq2_rptr >> i);
    end

    assign level_next = wbinnext - rbin_s;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            wlevel       <= level_next;
            walmost_full <= (level_next >= AF_TH);
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
            wdrop_cnt <= '0;
        end else if (drop) begin
            woverflow <= 1'b1;
            if (wclr_ovf)
                wdrop_cnt <= {{(DROPW-1){1'b0}}, 1'b1};
            else if (wdrop_cnt != {DROPW{1'b1}})
                wdrop_cnt <= wdrop_cnt + 1'b1;
        end else if (wclr_ovf) begin
            woverflow <= 1'b0;
            wdrop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_wptr_full_2.sv
// Directed bench for wptr_full_2 at the default size (depth 128, almost-full at 120).
module tb_wptr_full_2;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [7:0] wq2_rptr;
    logic       wclr_ovf;
    logic       wfull;
    logic [6:0] waddr;
    logic [7:0] wptr;
    logic [7:0] wlevel;
    logic       walmost_full;
    logic       woverflow;
    logic [7:0] wdrop_cnt;

    int checks = 0;
    int errors = 0;

    wptr_full_2 #(.ADDRSIZE(7), .AFULL_THRESH(120), .DROPW(8)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wclr_ovf(wclr_ovf), .wfull(wfull), .waddr(waddr), .wptr(wptr),
        .wlevel(wlevel), .walmost_full(walmost_full), .woverflow(woverflow),
        .wdrop_cnt(wdrop_cnt)
    );

    always #5 wclk = ~wclk;

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; winc = 1'b0; wq2_rptr = 8'h00; wclr_ovf = 1'b0;
        #2;
        checks++;
        if ({wfull, wptr, waddr, wlevel, walmost_full, woverflow, wdrop_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL reset: full=%0b wptr=%h waddr=%0d level=%0d af=%0b ovf=%0b drop=%0d, required all zero",
                     wfull, wptr, waddr, wlevel, walmost_full, woverflow, wdrop_cnt);
        end
        tick();
        wrst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        wq2_rptr = 8'h00; winc = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            tick();
            checks++;
            if (wlevel !== 8'(i) || walmost_full !== (i >= 120) || wfull !== (i == 128)) begin
                errors++;
                $display("FAIL fill[%0d]: level=%0d af=%0b full=%0b, required level=%0d af=%0b full=%0b",
                         i, wlevel, walmost_full, wfull, i, i >= 120, i == 128);
            end
        end
        checks++;
        if (wptr !== 8'hC0 || waddr !== 7'd0) begin
            errors++;
            $display("FAIL fill_ptr: wptr=%h waddr=%0d, required c0 and 0", wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (wptr !== 8'hC0 || woverflow !== 1'b1 || wdrop_cnt !== 8'(k)) begin
                errors++;
                $display("FAIL drop[%0d]: wptr=%h ovf=%0b drop=%0d, required c0 1 %0d", k, wptr, woverflow, wdrop_cnt, k);
            end
        end
        winc = 1'b0; wclr_ovf = 1'b1;
        tick();
        checks++;
        if (woverflow !== 1'b0 || wdrop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clear: ovf=%0b drop=%0d, required 0 0", woverflow, wdrop_cnt);
        end
        winc = 1'b1; wclr_ovf = 1'b1;
        tick();
        checks++;
        if (woverflow !== 1'b1 || wdrop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL drop_vs_clear: ovf=%0b drop=%0d, required 1 1", woverflow, wdrop_cnt);
        end
        wclr_ovf = 1'b0;
        for (int k = 0; k < 260; k++) tick();
        checks++;
        if (wdrop_cnt !== 8'hFF || wptr !== 8'hC0 || wlevel !== 8'd128 || wfull !== 1'b1) begin
            errors++;
            $display("FAIL saturate: drop=%0d wptr=%h level=%0d full=%0b, required 255 c0 128 1",
                     wdrop_cnt, wptr, wlevel, wfull);
        end
        winc = 1'b0; wclr_ovf = 1'b1;
        tick();
        wclr_ovf = 1'b0;
        checks++;
        if (woverflow !== 1'b0 || wdrop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clear2: ovf=%0b drop=%0d, required 0 0", woverflow, wdrop_cnt);
        end
    endtask

    task automatic test_read_advance();
        winc = 1'b0; wq2_rptr = 8'h07;
        tick();
        checks++;
        if (wfull !== 1'b0 || wlevel !== 8'd123 || walmost_full !== 1'b1) begin
            errors++;
            $display("FAIL read_adv: full=%0b level=%0d af=%0b, required 0 123 1", wfull, wlevel, walmost_full);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_bin;
        logic [7:0] prev_ptr;
        logic [7:0] exp_level;
        bit         wrapped;
        exp_bin = 8'd128;
        wrapped = 1'b0;
        winc = 1'b0; wq2_rptr = gray(8'd118);
        tick();
        checks++;
        if (wlevel !== 8'd10 || wfull !== 1'b0 || walmost_full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_start: level=%0d full=%0b af=%0b, required 10 0 0", wlevel, wfull, walmost_full);
        end
        for (int i = 0; i < 600; i++) begin
            prev_ptr  = wptr;
            wq2_rptr  = (i % 2 == 1) ? gray(exp_bin - 8'd9) : gray(exp_bin - 8'd10);
            exp_level = (i % 2 == 1) ? 8'd10 : 8'd11;
            winc = 1'b1;
            tick();
            exp_bin = exp_bin + 8'd1;
            if (exp_bin == 8'd0) wrapped = 1'b1;
            checks++;
            if (wptr !== gray(exp_bin) || $countones(wptr ^ prev_ptr) != 1 || waddr !== exp_bin[6:0]
                || wlevel !== exp_level || wfull !== 1'b0) begin
                errors++;
                $display("FAIL wrap[%0d]: wptr=%h waddr=%0d level=%0d full=%0b, required wptr=%h waddr=%0d level=%0d full=0",
                         i, wptr, waddr, wlevel, wfull, gray(exp_bin), exp_bin[6:0], exp_level);
            end
        end
        winc = 1'b0;
        checks++;
        if (!wrapped || wptr !== gray(8'd216)) begin
            errors++;
            $display("FAIL wrap_end: wptr=%h wrapped=%0b, required %h 1", wptr, wrapped, gray(8'd216));
        end
    endtask

    task automatic test_async_reset();
        wq2_rptr = 8'h00; winc = 1'b1;
        tick(); tick(); tick();
        #3;
        wrst_n = 1'b0;
        #1;
        checks++;
        if ({wfull, wptr, waddr, wlevel, walmost_full, woverflow, wdrop_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: full=%0b wptr=%h waddr=%0d level=%0d af=%0b ovf=%0b drop=%0d, required all zero",
                     wfull, wptr, waddr, wlevel, walmost_full, woverflow, wdrop_cnt);
        end
        tick();
        checks++;
        if (waddr !== 7'd0 || wptr !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: waddr=%0d wptr=%h, required 0 00", waddr, wptr);
        end
        wrst_n = 1'b1;
        tick();
        checks++;
        if (waddr !== 7'd1 || wptr !== 8'h01 || wlevel !== 8'd1) begin
            errors++;
            $display("FAIL resume: waddr=%0d wptr=%h level=%0d, required 1 01 1", waddr, wptr, wlevel);
        end
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_advance();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
